// File: rtl/fb_arb_pkg.sv
// Shared defaults and read-tag encoding for the frame-buffer port arbiter.
package fb_arb_pkg;
  localparam int AW_DEF     = 17;
  localparam int DW_DEF     = 8;
  localparam int WDEPTH_DEF = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_R0   = 2'd1,
    TAG_R1   = 2'd2
  } rd_tag_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Capture write FIFO of {addr,data}; head entry is visible combinationally from storage.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = WDEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;

  // Storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + PW'(1);
      if (pop)  r_rp <= r_rp + PW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign {rd_addr, rd_data} = r_mem[r_rp];
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: buffered capture writes first, then two
// round-robin readers with a 2-edge tagged read return.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int WDEPTH = WDEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  output logic          r0_ack,
  output logic          r0_valid,
  output logic [DW-1:0] r0_data,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  output logic          r1_ack,
  output logic          r1_valid,
  output logic [DW-1:0] r1_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  input  logic          ovf_clr,
  output logic          ovf
);
  localparam int CW = $clog2(WDEPTH) + 1;

  logic          w_full, w_empty, w_push, w_pop, w_drop, w_rd_slot, w_gnt1;
  logic [CW-1:0] w_cnt;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;

  logic          r_rr, r_ack0, r_ack1, r_we, r_ovf;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  rd_tag_e       r_tag_iss, r_tag_ret;

  // Any queued write owns the slot; a full FIFO only drops when it cannot pop.
  assign w_pop     = !w_empty;
  assign w_push    = wr_valid && (!w_full || w_pop);
  assign w_drop    = wr_valid && w_full && !w_pop;
  assign w_rd_slot = w_empty && (r0_req || r1_req);
  assign w_gnt1    = (r0_req && r1_req) ? r_rr : r1_req;

  fb_wr_fifo #(.AW(AW), .DW(DW), .DEPTH(WDEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (w_head_addr),
    .rd_data (w_head_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_ovf     <= 1'b0;
      r_tag_iss <= TAG_NONE;
      r_tag_ret <= TAG_NONE;
    end else begin
      r_we   <= w_pop;
      r_ack0 <= w_rd_slot && !w_gnt1;
      r_ack1 <= w_rd_slot &&  w_gnt1;
      if (w_pop) begin
        r_addr <= w_head_addr;
        r_din  <= w_head_data;
      end else if (w_rd_slot) begin
        r_addr <= w_gnt1 ? r1_addr : r0_addr;
        r_rr   <= !w_gnt1;
      end
      r_tag_iss <= w_rd_slot ? (w_gnt1 ? TAG_R1 : TAG_R0) : TAG_NONE;
      r_tag_ret <= r_tag_iss;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // FIFO occupancy flags must agree with its count.
  always_ff @(posedge clk) begin
    if (!rst) assert (w_empty == (w_cnt == '0) && !(w_full && w_empty));
  end

  assign ram_we   = r_we;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign r0_ack   = r_ack0;
  assign r1_ack   = r_ack1;
  assign r0_valid = (r_tag_ret == TAG_R0);
  assign r1_valid = (r_tag_ret == TAG_R1);
  assign r0_data  = r0_valid ? ram_dout : '0;
  assign r1_data  = r1_valid ? ram_dout : '0;
  assign ovf      = r_ovf;
endmodule
